// File: rtl/lfsr_pkg.sv
// Shared definitions for the 8-bit LFSR pattern generator/checker pair:
// sequence step function, checker FSM states and a byte popcount helper.
package lfsr_pkg;

    localparam int LFSR_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        SEED,
        VERIFY,
        LOCKED
    } chk_state_t;

    // One step of the pattern sequence; 0x00 maps to itself (lockup value).
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
        return {q[0], q[7], q[6], q[5], q[4] ^ q[0], q[3] ^ q[0], q[2] ^ q[0], q[1]};
    endfunction

    // Number of set bits in a byte (0..8).
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/lfsr_checker.sv
// Receive-side LFSR sequence checker: seeds a local predictor from the
// incoming byte stream, acquires lock after LOCK_CNT consecutive matches,
// then flywheels and counts mismatches until LOSS_CNT consecutive misses.
// Optional: LFSR_CHECKER_BIT_ERR_EN adds a saturating bit-error counter.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int ERR_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              din_vld,
    input  logic [LFSR_W-1:0] din,
    input  logic              clr_err,
    output logic              locked,
    output logic              err_pulse,
    output logic [ERR_W-1:0]  err_cnt
`ifdef LFSR_CHECKER_BIT_ERR_EN
    ,
    output logic [ERR_W-1:0]  bit_err_cnt
`endif
);

    localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);
    localparam logic [3:0] LOSS_N = 4'(LOSS_CNT);

    chk_state_t        state_q;
    logic [LFSR_W-1:0] pred_q;
    logic [3:0]        match_q;
    logic [3:0]        miss_q;
    logic              locked_q;
    logic              err_pulse_q;
    logic [ERR_W-1:0]  err_cnt_q;
    logic [ERR_W-1:0]  err_cnt_d;

    logic [LFSR_W-1:0] din_next;
    logic [LFSR_W-1:0] pred_next;
    logic [3:0]        match_inc;
    logic [3:0]        miss_inc;
    logic              count_err;

    // Next-sequence values, counter increments and the "counted error" qualifier.
    always_comb begin
        din_next  = lfsr_next(din);
        pred_next = lfsr_next(pred_q);
        match_inc = match_q + 4'd1;
        miss_inc  = miss_q + 4'd1;
        count_err = en && din_vld && (state_q == LOCKED) && (din != pred_q);
    end

    // Saturating error counter; a clear coincident with an error leaves 1.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clr_err) begin
            err_cnt_d = count_err ? ERR_W'(1) : '0;
        end else if (count_err && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end
    end

    // Checker FSM with predictor, match/miss counters and registered status.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pred_q      <= '0;
            match_q     <= '0;
            miss_q      <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            err_cnt_q   <= err_cnt_d;
            err_pulse_q <= count_err;
            if (!en) begin
                state_q  <= IDLE;
                locked_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= SEED;
                    end
                    SEED: begin
                        if (din_vld && (din != '0)) begin
                            pred_q  <= din_next;
                            match_q <= '0;
                            state_q <= VERIFY;
                        end
                    end
                    VERIFY: begin
                        if (din_vld) begin
                            if (din == pred_q) begin
                                pred_q  <= din_next;
                                match_q <= match_inc;
                                if (match_inc == LOCK_N) begin
                                    state_q  <= LOCKED;
                                    miss_q   <= '0;
                                    locked_q <= 1'b1;
                                end
                            end else if (din != '0) begin
                                pred_q  <= din_next;
                                match_q <= '0;
                            end else begin
                                state_q <= SEED;
                            end
                        end
                    end
                    LOCKED: begin
                        if (din_vld) begin
                            // Flywheel: the received byte never reloads the predictor here.
                            pred_q <= pred_next;
                            if (din == pred_q) begin
                                miss_q <= '0;
                            end else begin
                                miss_q <= miss_inc;
                                if (miss_inc == LOSS_N) begin
                                    state_q  <= SEED;
                                    locked_q <= 1'b0;
                                end
                            end
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;

`ifdef LFSR_CHECKER_BIT_ERR_EN
    logic [ERR_W-1:0] bit_err_q;
    logic [ERR_W-1:0] bit_err_d;
    logic [3:0]       bit_pop;
    logic [ERR_W:0]   bit_sum;

    // Saturating accumulation of flipped bits per counted error.
    always_comb begin
        bit_pop   = popcount8(din ^ pred_q);
        bit_sum   = {1'b0, bit_err_q} + (ERR_W+1)'(bit_pop);
        bit_err_d = bit_err_q;
        if (clr_err) begin
            bit_err_d = count_err ? ERR_W'(bit_pop) : '0;
        end else if (count_err) begin
            bit_err_d = bit_sum[ERR_W] ? '1 : bit_sum[ERR_W-1:0];
        end
    end

    // Bit-error counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_err_q <= '0;
        end else begin
            bit_err_q <= bit_err_d;
        end
    end

    assign bit_err_cnt = bit_err_q;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Self-checking bench for lfsr_checker: default instance checked against a
// behavioural scoreboard, second instance (ERR_W=4, LOSS_CNT=15) for saturation.
module tb_lfsr_checker;

    typedef struct packed {
        logic       r;
        logic       e;
        logic       v;
        logic [7:0] d;
        logic       c;
    } stim_t;

    typedef struct packed {
        logic        l;
        logic        p;
        logic [15:0] e;
    } exp_t;

    typedef struct packed {
        logic       l;
        logic       p;
        logic [3:0] e;
        logic [3:0] b;
    } sexp_t;

    logic        clk;
    logic        rst, en, din_vld, clr_err;
    logic [7:0]  din;
    logic        locked, err_pulse;
    logic [15:0] err_cnt;

    logic        s_rst, s_en, s_vld, s_clr;
    logic [7:0]  s_din;
    logic        s_locked, s_err_pulse;
    logic [3:0]  s_err_cnt;

`ifdef LFSR_CHECKER_BIT_ERR_EN
    logic [15:0] bit_err_cnt;
    logic [3:0]  s_bit_err_cnt;
`endif

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    stim_t stim_q[$];
    exp_t  exp_q[$];
    sexp_t sexp_q[$];

    // Behavioural reference state: 0 idle, 1 seed, 2 verify, 3 locked.
    int         m_st = 0;
    logic [7:0] m_pred = '0;
    int         m_match = 0;
    int         m_miss = 0;
    logic       m_locked = 1'b0;
    logic       m_pulse = 1'b0;
    int         m_err = 0;

    lfsr_checker #(.LOCK_CNT(4), .LOSS_CNT(3), .ERR_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .din_vld(din_vld), .din(din),
        .clr_err(clr_err), .locked(locked), .err_pulse(err_pulse),
        .err_cnt(err_cnt)
`ifdef LFSR_CHECKER_BIT_ERR_EN
        , .bit_err_cnt(bit_err_cnt)
`endif
    );

    lfsr_checker #(.LOCK_CNT(4), .LOSS_CNT(15), .ERR_W(4)) dut_s (
        .clk(clk), .rst(s_rst), .en(s_en), .din_vld(s_vld), .din(s_din),
        .clr_err(s_clr), .locked(s_locked), .err_pulse(s_err_pulse),
        .err_cnt(s_err_cnt)
`ifdef LFSR_CHECKER_BIT_ERR_EN
        , .bit_err_cnt(s_bit_err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Galois-form right shift with feedback mask 0x8E.
    function automatic logic [7:0] tb_nx(input logic [7:0] q);
        return (q >> 1) ^ (q[0] ? 8'h8E : 8'h00);
    endfunction

    task automatic add(input logic r, input logic e, input logic v,
                       input logic [7:0] d, input logic c);
        stim_t s;
        s.r = r; s.e = e; s.v = v; s.d = d; s.c = c;
        stim_q.push_back(s);
    endtask

    // en low, en high (IDLE->SEED), then the seed plus four matches.
    task automatic add_lock_run();
        add(0, 0, 0, 8'h00, 0);
        add(0, 1, 0, 8'h00, 0);
        add(0, 1, 1, 8'h01, 0);
        add(0, 1, 1, 8'h8E, 0);
        add(0, 1, 1, 8'h47, 0);
        add(0, 1, 1, 8'hAD, 0);
        add(0, 1, 1, 8'hD8, 0);
    endtask

    // Drive one cycle, advance the reference model and queue its expectation.
    task automatic step(input stim_t s);
        exp_t x;
        logic hit;
        rst = s.r; en = s.e; din_vld = s.v; din = s.d; clr_err = s.c;
        if (s.r) begin
            m_st = 0; m_pred = '0; m_match = 0; m_miss = 0;
            m_locked = 1'b0; m_pulse = 1'b0; m_err = 0;
        end else begin
            hit = s.e && s.v && (m_st == 3) && (s.d != m_pred);
            if (s.c) m_err = hit ? 1 : 0;
            else if (hit && m_err < 65535) m_err++;
            m_pulse = hit;
            if (!s.e) begin
                m_st = 0;
            end else begin
                case (m_st)
                    0: m_st = 1;
                    1: if (s.v && s.d != 8'h00) begin
                           m_pred = tb_nx(s.d); m_match = 0; m_st = 2;
                       end
                    2: if (s.v) begin
                           if (s.d == m_pred) begin
                               m_pred = tb_nx(s.d); m_match++;
                               if (m_match == 4) begin m_st = 3; m_miss = 0; end
                           end else if (s.d != 8'h00) begin
                               m_pred = tb_nx(s.d); m_match = 0;
                           end else begin
                               m_st = 1;
                           end
                       end
                    default: if (s.v) begin
                           m_pred = tb_nx(m_pred);
                           if (hit) begin
                               m_miss++;
                               if (m_miss == 3) m_st = 1;
                           end else begin
                               m_miss = 0;
                           end
                       end
                endcase
            end
            m_locked = (m_st == 3);
        end
        x.l = m_locked; x.p = m_pulse; x.e = 16'(m_err);
        exp_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic s_step(input logic r, input logic e, input logic v, input logic [7:0] d);
        s_rst = r; s_en = e; s_vld = v; s_din = d; s_clr = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        stim_t s;
        exp_t x;
        int k = 0;
        add(1, 0, 0, 8'h00, 0);
        add(1, 0, 0, 8'h00, 0);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            step(s);
            x = exp_q.pop_front();
            n_cmp++;
            if ({locked, err_pulse, err_cnt} !== {x.l, x.p, x.e}) begin
                n_bad++;
                $display("FAIL reset[%0d]: got locked=%b pulse=%b err=%0d, want %b %b %0d",
                         k, locked, err_pulse, err_cnt, x.l, x.p, x.e);
            end
            k++;
        end
        n_cmp++;
        if ({locked, err_pulse, err_cnt} !== 18'd0) begin
            n_bad++;
            $display("FAIL reset_zero: got %b/%b/%0d want 0/0/0", locked, err_pulse, err_cnt);
        end
    endtask

    task automatic test_lock();
        stim_t s;
        exp_t x;
        int k = 0;
        add_lock_run();
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            step(s);
            x = exp_q.pop_front();
            n_cmp++;
            if ({locked, err_pulse, err_cnt} !== {x.l, x.p, x.e}) begin
                n_bad++;
                $display("FAIL lock[%0d]: got locked=%b pulse=%b err=%0d, want %b %b %0d",
                         k, locked, err_pulse, err_cnt, x.l, x.p, x.e);
            end
            k++;
        end
        n_cmp++;
        if (locked !== 1'b1 || err_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL lock_final: got locked=%b err=%0d want 1 0", locked, err_cnt);
        end
    endtask

    task automatic test_zero_seed();
        stim_t s;
        exp_t x;
        int k = 0;
        add(0, 0, 0, 8'h00, 0);
        add(0, 1, 0, 8'h00, 0);
        add(0, 1, 1, 8'h00, 0);
        add(0, 1, 1, 8'h00, 0);
        add(0, 1, 1, 8'h01, 0);
        add(0, 1, 1, 8'h55, 0);
        add(0, 1, 1, 8'h8E, 0);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            step(s);
            x = exp_q.pop_front();
            n_cmp++;
            if ({locked, err_pulse, err_cnt} !== {x.l, x.p, x.e}) begin
                n_bad++;
                $display("FAIL zero_seed[%0d]: got locked=%b pulse=%b err=%0d, want %b %b %0d",
                         k, locked, err_pulse, err_cnt, x.l, x.p, x.e);
            end
            k++;
        end
        n_cmp++;
        if (locked !== 1'b0 || err_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL zero_seed_final: got locked=%b err=%0d want 0 0", locked, err_cnt);
        end
    endtask

    task automatic test_single_error();
        stim_t s;
        exp_t x;
        int k = 0;
        logic [7:0] p;
        add_lock_run();
        p = tb_nx(8'hD8);
        add(0, 1, 1, 8'h00, 0);
        p = tb_nx(p);
        add(0, 1, 1, p, 0);
        p = tb_nx(p);
        add(0, 1, 1, p, 0);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            step(s);
            x = exp_q.pop_front();
            n_cmp++;
            if ({locked, err_pulse, err_cnt} !== {x.l, x.p, x.e}) begin
                n_bad++;
                $display("FAIL single_err[%0d]: got locked=%b pulse=%b err=%0d, want %b %b %0d",
                         k, locked, err_pulse, err_cnt, x.l, x.p, x.e);
            end
            k++;
        end
        n_cmp++;
        if (locked !== 1'b1 || err_cnt !== 16'd1 || err_pulse !== 1'b0) begin
            n_bad++;
            $display("FAIL single_err_final: got locked=%b pulse=%b err=%0d want 1 0 1",
                     locked, err_pulse, err_cnt);
        end
    endtask

    task automatic test_loss_of_lock();
        stim_t s;
        exp_t x;
        int k = 0;
        add(0, 1, 1, 8'h00, 0);
        add(0, 1, 1, 8'h00, 0);
        add(0, 1, 1, 8'h00, 0);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            step(s);
            x = exp_q.pop_front();
            n_cmp++;
            if ({locked, err_pulse, err_cnt} !== {x.l, x.p, x.e}) begin
                n_bad++;
                $display("FAIL loss[%0d]: got locked=%b pulse=%b err=%0d, want %b %b %0d",
                         k, locked, err_pulse, err_cnt, x.l, x.p, x.e);
            end
            k++;
        end
        n_cmp++;
        if (locked !== 1'b0 || err_cnt !== 16'd4) begin
            n_bad++;
            $display("FAIL loss_drop: got locked=%b err=%0d want 0 4", locked, err_cnt);
        end
        // Already in SEED: a fresh run relocks without toggling en.
        add(0, 1, 1, 8'h01, 0);
        add(0, 1, 1, 8'h8E, 0);
        add(0, 1, 1, 8'h47, 0);
        add(0, 1, 1, 8'hAD, 0);
        add(0, 1, 1, 8'hD8, 0);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            step(s);
            x = exp_q.pop_front();
            n_cmp++;
            if ({locked, err_pulse, err_cnt} !== {x.l, x.p, x.e}) begin
                n_bad++;
                $display("FAIL relock[%0d]: got locked=%b pulse=%b err=%0d, want %b %b %0d",
                         k, locked, err_pulse, err_cnt, x.l, x.p, x.e);
            end
            k++;
        end
        n_cmp++;
        if (locked !== 1'b1 || err_cnt !== 16'd4) begin
            n_bad++;
            $display("FAIL relock_final: got locked=%b err=%0d want 1 4", locked, err_cnt);
        end
    endtask

    task automatic test_gaps_ctrl();
        stim_t s;
        exp_t x;
        int k = 0;
        logic [7:0] p;
        p = tb_nx(8'hD8);
        add(0, 1, 1, p, 0);
        add(0, 1, 0, 8'h00, 0);
        p = tb_nx(p);
        add(0, 1, 1, p, 0);
        add(0, 1, 0, 8'hFF, 0);
        add(0, 1, 0, 8'h00, 0);
        p = tb_nx(p);
        add(0, 1, 1, p, 0);
        add(0, 1, 0, 8'h00, 1);
        add(0, 1, 1, 8'h00, 1);
        add(0, 0, 0, 8'h00, 0);
        add(0, 0, 0, 8'h00, 0);
        add_lock_run();
        add(1, 1, 0, 8'h00, 0);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            step(s);
            x = exp_q.pop_front();
            n_cmp++;
            if ({locked, err_pulse, err_cnt} !== {x.l, x.p, x.e}) begin
                n_bad++;
                $display("FAIL gaps_ctrl[%0d]: got locked=%b pulse=%b err=%0d, want %b %b %0d",
                         k, locked, err_pulse, err_cnt, x.l, x.p, x.e);
            end
            k++;
        end
        n_cmp++;
        if ({locked, err_pulse, err_cnt} !== 18'd0) begin
            n_bad++;
            $display("FAIL rst_midlock: got %b/%b/%0d want 0/0/0", locked, err_pulse, err_cnt);
        end
    endtask

    task automatic test_saturation();
        sexp_t x;
        logic [7:0] p;
        logic [7:0] seeds [5];
        logic wrong;
        int n = 0;
        seeds[0] = 8'h01; seeds[1] = 8'h8E; seeds[2] = 8'h47; seeds[3] = 8'hAD; seeds[4] = 8'hD8;
        s_step(1, 0, 0, 8'h00);
        s_step(0, 1, 0, 8'h00);
        for (int i = 0; i < 5; i++) s_step(0, 1, 1, seeds[i]);
        n_cmp++;
        if (s_locked !== 1'b1 || s_err_cnt !== 4'd0) begin
            n_bad++;
            $display("FAIL sat_lock: got locked=%b err=%0d want 1 0", s_locked, s_err_cnt);
        end
        p = tb_nx(8'hD8);
        for (int i = 0; i < 21; i++) begin
            wrong = (i != 10);
            if (wrong) n++;
            x.l = 1'b1;
            x.p = wrong;
            x.e = (n > 15) ? 4'd15 : 4'(n);
            x.b = (2 * n > 15) ? 4'd15 : 4'(2 * n);
            sexp_q.push_back(x);
            s_step(0, 1, 1, wrong ? (p ^ 8'h03) : p);
            p = tb_nx(p);
            x = sexp_q.pop_front();
            n_cmp++;
`ifdef LFSR_CHECKER_BIT_ERR_EN
            if ({s_locked, s_err_pulse, s_err_cnt, s_bit_err_cnt} !== {x.l, x.p, x.e, x.b}) begin
                n_bad++;
                $display("FAIL sat[%0d]: got locked=%b pulse=%b err=%0d bit=%0d, want %b %b %0d %0d",
                         i, s_locked, s_err_pulse, s_err_cnt, s_bit_err_cnt, x.l, x.p, x.e, x.b);
            end
`else
            if ({s_locked, s_err_pulse, s_err_cnt} !== {x.l, x.p, x.e}) begin
                n_bad++;
                $display("FAIL sat[%0d]: got locked=%b pulse=%b err=%0d, want %b %b %0d",
                         i, s_locked, s_err_pulse, s_err_cnt, x.l, x.p, x.e);
            end
`endif
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; din_vld = 1'b0; din = '0; clr_err = 1'b0;
        s_rst = 1'b1; s_en = 1'b0; s_vld = 1'b0; s_din = '0; s_clr = 1'b0;
        test_reset();
        test_lock();
        test_zero_seed();
        test_single_error();
        test_loss_of_lock();
        test_gaps_ctrl();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
